// File: rtl/vip_rgb565_pack.sv
// rtl/vip_rgb565_pack.sv - VIP RGB stream to RGB565 two-pixel Avalon-ST packer with show-ahead FIFO
//
// Purpose:
//   Converts each valid VIP pixel to RGB565, packs two pixels per 32-bit
//   word, tags the first/last word of a frame with sop/eop and queues the
//   words in a show-ahead FIFO that drives an Avalon-ST source. Overflow and
//   short frames are reported through sticky flags.
//
// Configuration macro:
//   VIP_PACK_SWAP_EN - when defined, the even pixel goes to [31:16] and the
//                      odd pixel to [15:0]; otherwise even in [15:0], odd in
//                      [31:16]. sop/eop tagging is the same in both builds.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   in_href, in_vsync   line active / frame blanking (pixel valid = href & ~vsync)
//   in_r, in_g, in_b    pixel colour, BITS each
//   st_data/valid/ready Avalon-ST source, 32-bit packed words
//   st_sop, st_eop      first / last word of a frame
//   status_clr          clears the sticky flags
//   overflow            sticky: a completed word met a full FIFO and was lost
//   short_frame         sticky: vsync rose before the frame's eop word
//   frame_cnt           complete frames pushed into the FIFO (wrapping)

module vip_rgb565_pack #(
    parameter int BITS       = 8,
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 960,
    parameter int FIFO_DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_href,
    input  logic            in_vsync,
    input  logic [BITS-1:0] in_r,
    input  logic [BITS-1:0] in_g,
    input  logic [BITS-1:0] in_b,
    output logic [31:0]     st_data,
    output logic            st_valid,
    input  logic            st_ready,
    output logic            st_sop,
    output logic            st_eop,
    input  logic            status_clr,
    output logic            overflow,
    output logic            short_frame,
    output logic [15:0]     frame_cnt
);

    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int NW    = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DROP
    } state_t;

    state_t state, state_nx;

    // ------------------------------------------------------------------
    // Input qualification and colour conversion
    // ------------------------------------------------------------------
    logic        vsync_q;
    logic        vsync_rise;
    logic        pix_valid;
    logic [15:0] pix;

    assign vsync_rise = in_vsync & ~vsync_q;
    assign pix_valid  = in_href & ~in_vsync;
    assign pix        = {in_r[BITS-1 -: 5], in_g[BITS-1 -: 6], in_b[BITS-1 -: 5]};

    // Truncated low colour bits are intentionally dropped.
    logic unused_lsbs;
    if (BITS > 6) begin : g_lsb_g
        assign unused_lsbs = ^{in_r[BITS-6:0], in_g[BITS-7:0], in_b[BITS-6:0]};
    end else begin : g_lsb_no_g
        assign unused_lsbs = ^{in_r[BITS-6:0], in_b[BITS-6:0]};
    end

    // ------------------------------------------------------------------
    // Pixel counter and half-word register
    // ------------------------------------------------------------------
    logic [CW-1:0] pix_cnt;
    logic [15:0]   half_pix;
    logic          accept;
    logic          word_done;
    logic          last_pix;
    logic [31:0]   word_data;

    assign accept    = (state == S_ACTIVE) && pix_valid;
    assign word_done = accept && pix_cnt[0];
    assign last_pix  = (pix_cnt == CW'(TOTAL - 1));

`ifdef VIP_PACK_SWAP_EN
    assign word_data = {half_pix, pix};
`else
    assign word_data = {pix, half_pix};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q  <= 1'b0;
            pix_cnt  <= '0;
            half_pix <= '0;
        end else begin
            vsync_q <= in_vsync;
            if (vsync_rise) begin
                // Any frame boundary discards a pending half-word.
                pix_cnt  <= '0;
                half_pix <= '0;
            end else if (accept) begin
                pix_cnt <= last_pix ? '0 : pix_cnt + CW'(1);
                if (!pix_cnt[0]) begin
                    half_pix <= pix;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Push stage: a completed word is registered here and written into the
    // FIFO one edge later, which is where the full check happens.
    // ------------------------------------------------------------------
    logic        stg_valid;
    logic [31:0] stg_data;
    logic        stg_sop;
    logic        stg_eop;

    always_ff @(posedge clk) begin
        if (reset) begin
            stg_valid <= 1'b0;
            stg_data  <= '0;
            stg_sop   <= 1'b0;
            stg_eop   <= 1'b0;
        end else begin
            stg_valid <= word_done;
            if (word_done) begin
                stg_data <= word_data;
                stg_sop  <= (pix_cnt == CW'(1));
                stg_eop  <= last_pix;
            end
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO, entry = {eop, sop, data}
    // ------------------------------------------------------------------
    logic [33:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [NW-1:0] count;
    logic          full;
    logic          empty;
    logic          push_ok;
    logic          push_drop;
    logic          pop;
    logic [33:0]   head;

    assign full      = (count == NW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    // A pop in the same cycle does not make room for a push.
    assign push_ok   = stg_valid && !full;
    assign push_drop = stg_valid && full;
    assign pop       = !empty && st_ready;
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {stg_eop, stg_sop, stg_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head is gated so the outputs read zero whenever the FIFO is empty.
    assign st_valid = !empty;
    assign st_data  = empty ? 32'd0 : head[31:0];
    assign st_sop   = !empty && head[32];
    assign st_eop   = !empty && head[33];

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (vsync_rise) begin
                    state_nx = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (vsync_rise) begin
                    state_nx = S_ACTIVE;
                end else if (word_done && last_pix) begin
                    state_nx = S_IDLE;
                end
            end
            S_DROP: begin
                if (vsync_rise) begin
                    state_nx = S_ACTIVE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        // A lost word abandons the rest of the frame unless a new frame is
        // starting in this very cycle.
        if (push_drop && !vsync_rise) begin
            state_nx = S_DROP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------
    logic short_set;

    assign short_set = (state == S_ACTIVE) && vsync_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow    <= 1'b0;
            short_frame <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            // A set event in the same cycle as a clear wins.
            overflow    <= (overflow    && !status_clr) || push_drop;
            short_frame <= (short_frame && !status_clr) || short_set;
            if (push_ok && stg_eop) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vip_rgb565_pack.sv
// tb/tb_vip_rgb565_pack.sv - self-checking bench for vip_rgb565_pack
module tb_vip_rgb565_pack;

    localparam int BITS = 8;
    localparam int W    = 4;
    localparam int H    = 2;
    localparam int D    = 4;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_href = 1'b0;
    logic        in_vsync = 1'b0;
    logic [7:0]  in_r = '0;
    logic [7:0]  in_g = '0;
    logic [7:0]  in_b = '0;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_ready = 1'b0;
    logic        st_sop;
    logic        st_eop;
    logic        status_clr = 1'b0;
    logic        overflow;
    logic        short_frame;
    logic [15:0] frame_cnt;

    vip_rgb565_pack #(
        .BITS(BITS), .WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .reset(reset),
        .in_href(in_href), .in_vsync(in_vsync),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
        .st_sop(st_sop), .st_eop(st_eop),
        .status_clr(status_clr), .overflow(overflow),
        .short_frame(short_frame), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_fc = 0;
    logic [33:0] exp_q[$];
    logic [7:0]  pr[NPIX];
    logic [7:0]  pg[NPIX];
    logic [7:0]  pb[NPIX];

    typedef struct {
        logic [7:0]  r0, g0, b0, r1, g1, b1;
        logic [31:0] exp_word;
    } vec_t;
    vec_t tbl[4];

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to565(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

    function automatic logic [31:0] pack(input logic [15:0] p0, input logic [15:0] p1);
`ifdef VIP_PACK_SWAP_EN
        return {p0, p1};
`else
        return {p1, p0};
`endif
    endfunction

    // Scoreboard: every transfer is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && st_valid && st_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %h expected none", {st_eop, st_sop, st_data});
            end else begin
                check("word", {st_eop, st_sop, st_data}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vsync_pulse();
        in_href  = 1'b0;
        in_vsync = 1'b1;
        tick();
        tick();
        in_vsync = 1'b0;
        tick();
    endtask

    task automatic drive_frame(input int npix, input bit vs);
        if (vs) vsync_pulse();
        for (int i = 0; i < npix; i++) begin
            if (i != 0 && (i % W) == 0) begin
                in_href = 1'b0;
                tick();
            end
            in_href = 1'b1;
            in_r = pr[i];
            in_g = pg[i];
            in_b = pb[i];
            tick();
        end
        in_href = 1'b0;
        tick();
    endtask

    task automatic push_exp(input int nwords, input bit with_eop);
        for (int i = 0; i < nwords; i++) begin
            exp_q.push_back({with_eop && (i == NPIX/2 - 1), i == 0,
                             pack(to565(pr[2*i], pg[2*i], pb[2*i]),
                                  to565(pr[2*i+1], pg[2*i+1], pb[2*i+1]))});
        end
    endtask

    task automatic rand_pixels();
        for (int i = 0; i < NPIX; i++) begin
            pr[i] = 8'($urandom);
            pg[i] = 8'($urandom);
            pb[i] = 8'($urandom);
        end
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        check("drain", 34'(exp_q.size()), 34'd0);
    endtask

    task automatic clear_pulse();
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'hF8, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF8, 32'h0000_0000};
        tbl[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFF};
        tbl[2] = '{8'h00, 8'hFC, 8'h00, 8'h08, 8'h04, 8'h08, 32'h0000_0000};
        tbl[3] = '{8'h07, 8'h03, 8'h07, 8'h80, 8'h80, 8'h80, 32'h0000_0000};
`ifdef VIP_PACK_SWAP_EN
        tbl[0].exp_word = 32'hF800_001F;
        tbl[2].exp_word = 32'h07E0_0821;
        tbl[3].exp_word = 32'h0000_8410;
`else
        tbl[0].exp_word = 32'h001F_F800;
        tbl[2].exp_word = 32'h0821_07E0;
        tbl[3].exp_word = 32'h8410_0000;
`endif

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_valid", 34'(st_valid), 34'd0);
        check("rst_head", {st_eop, st_sop, st_data}, 34'd0);
        check("rst_flags", {32'd0, overflow, short_frame}, 34'd0);
        check("rst_fcnt", 34'(frame_cnt), 34'd0);

        // All-white frame
        st_ready = 1'b1;
        for (int i = 0; i < NPIX; i++) begin
            pr[i] = 8'hFF; pg[i] = 8'hFF; pb[i] = 8'hFF;
        end
        for (int i = 0; i < NPIX/2; i++)
            exp_q.push_back({i == NPIX/2 - 1, i == 0, 32'hFFFF_FFFF});
        drive_frame(NPIX, 1'b1);
        wait_drain(20);
        tick(); tick();
        exp_fc++;
        check("white_fcnt", 34'(frame_cnt), 34'(exp_fc));
        check("white_flags", {32'd0, overflow, short_frame}, 34'd0);
        check("white_empty", 34'(st_valid), 34'd0);

        // Table-driven colour packing
        for (int i = 0; i < 4; i++) begin
            pr[2*i] = tbl[i].r0;   pg[2*i] = tbl[i].g0;   pb[2*i] = tbl[i].b0;
            pr[2*i+1] = tbl[i].r1; pg[2*i+1] = tbl[i].g1; pb[2*i+1] = tbl[i].b1;
            exp_q.push_back({i == 3, i == 0, tbl[i].exp_word});
        end
        drive_frame(NPIX, 1'b1);
        wait_drain(20);
        exp_fc++;
        tick();
        check("tbl_fcnt", 34'(frame_cnt), 34'(exp_fc));

        // Backpressure: whole frame held in a 4-deep FIFO
        st_ready = 1'b0;
        rand_pixels();
        push_exp(NPIX/2, 1'b1);
        drive_frame(NPIX, 1'b1);
        exp_fc++;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_valid", 34'(st_valid), 34'd1);
            check("bp_head", {st_eop, st_sop, st_data}, exp_q[0]);
        end
        check("bp_ovf", 34'(overflow), 34'd0);
        check("bp_fcnt", 34'(frame_cnt), 34'(exp_fc));
        st_ready = 1'b1;
        repeat (4) tick();
        check("bp_4xfer", 34'(exp_q.size()), 34'd0);
        check("bp_empty", 34'(st_valid), 34'd0);

        // Overflow: second frame meets a full FIFO
        st_ready = 1'b0;
        rand_pixels();
        push_exp(NPIX/2, 1'b1);
        drive_frame(NPIX, 1'b1);
        exp_fc++;
        rand_pixels();
        drive_frame(NPIX, 1'b1);
        repeat (3) tick();
        check("ovf_set", 34'(overflow), 34'd1);
        check("ovf_fcnt", 34'(frame_cnt), 34'(exp_fc));
        st_ready = 1'b1;
        wait_drain(20);
        tick();
        check("ovf_drained", 34'(st_valid), 34'd0);
        rand_pixels();
        push_exp(NPIX/2, 1'b1);
        drive_frame(NPIX, 1'b1);
        wait_drain(20);
        exp_fc++;
        tick();
        check("ovf_recover_fcnt", 34'(frame_cnt), 34'(exp_fc));
        check("ovf_sticky", 34'(overflow), 34'd1);
        clear_pulse();
        check("ovf_clr", 34'(overflow), 34'd0);

        // Short frame: vsync after 5 pixels
        rand_pixels();
        push_exp(2, 1'b0);
        drive_frame(5, 1'b1);
        vsync_pulse();
        check("short_set", 34'(short_frame), 34'd1);
        rand_pixels();
        push_exp(NPIX/2, 1'b1);
        drive_frame(NPIX, 1'b0);
        wait_drain(20);
        exp_fc++;
        tick();
        check("short_next_fcnt", 34'(frame_cnt), 34'(exp_fc));
        check("short_sticky", 34'(short_frame), 34'd1);
        clear_pulse();
        check("short_clr", 34'(short_frame), 34'd0);

        // Reset mid-frame with 3 words queued and short_frame set
        st_ready = 1'b0;
        rand_pixels();
        drive_frame(6, 1'b1);
        vsync_pulse();
        tick();
        check("pre_rst_valid", 34'(st_valid), 34'd1);
        check("pre_rst_short", 34'(short_frame), 34'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        exp_fc = 0;
        check("mrst_valid", 34'(st_valid), 34'd0);
        check("mrst_flags", {32'd0, overflow, short_frame}, 34'd0);
        check("mrst_fcnt", 34'(frame_cnt), 34'd0);
        st_ready = 1'b1;
        rand_pixels();
        drive_frame(NPIX, 1'b0);
        repeat (3) tick();
        check("mrst_ignored", 34'(st_valid), 34'd0);
        rand_pixels();
        push_exp(NPIX/2, 1'b1);
        drive_frame(NPIX, 1'b1);
        wait_drain(20);
        exp_fc++;
        tick();
        check("mrst_clean_fcnt", 34'(frame_cnt), 34'(exp_fc));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
